// File: rtl/bcd_to_binary_seq.sv
// Multi-cycle packed-BCD to unsigned binary converter (reverse double-dabble).
// Define BCD2BIN_FAST_EN to perform two shift+correct steps per clock edge.
module bcd_to_binary_seq #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int WORK_W = BCD_W + BIN_W;

`ifdef BCD2BIN_FAST_EN
  localparam int STEPS_PER_EDGE = 2;
`else
  localparam int STEPS_PER_EDGE = 1;
`endif

  localparam int N_EDGES = (BIN_W + STEPS_PER_EDGE - 1) / STEPS_PER_EDGE;
  localparam int CNT_W   = $clog2(N_EDGES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_EDGES - 1);

  // Bits needed to hold 10^d - 1, i.e. ceil(log2(10^d)).
  function automatic int min_bin_w(input int d);
    longint unsigned m;
    int              n;
    m = 1;
    n = 0;
    for (int i = 0; i < d; i++) m = m * 10;
    m = m - 1;
    while (m != 0) begin
      m = m >> 1;
      n++;
    end
    return n;
  endfunction

  localparam int MIN_BIN_W = min_bin_w(DIGITS);

  if (DIGITS < 1) begin : g_digits_check
    $error("bcd_to_binary_seq: DIGITS must be >= 1");
  end
  if (BIN_W < MIN_BIN_W) begin : g_width_check
    $error("bcd_to_binary_seq: BIN_W too narrow for DIGITS");
  end

  // One reverse double-dabble step: shift right, then pull every digit >= 8 down by 3.
  function automatic logic [WORK_W-1:0] dabble_step(input logic [WORK_W-1:0] w);
    logic [WORK_W-1:0] s;
    s = w >> 1;
    for (int i = 0; i < DIGITS; i++) begin
      if (s[BIN_W + 4*i + 3]) s[BIN_W + 4*i +: 4] = s[BIN_W + 4*i +: 4] - 4'd3;
    end
    return s;
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_e;

  state_e            state_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [BIN_W-1:0]  bin_q;
  logic              err_q;
  logic [WORK_W-1:0] work_q;
  logic [WORK_W-1:0] work_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              digit_err;

  // NOTE: combinational blocks use blocking '=' with a default first so no latch is inferred.
  always_comb begin
    digit_err = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) digit_err = 1'b1;
    end
  end

`ifdef BCD2BIN_FAST_EN
  logic [WORK_W-1:0] step1;
  logic [WORK_W-1:0] step2;

  always_comb begin
    step1 = dabble_step(work_q);
    step2 = dabble_step(step1);
    // With an odd BIN_W the last edge has only one step left to do.
    if ((cnt_q == LAST_CNT) && (BIN_W % 2 == 1)) work_d = step1;
    else                                          work_d = step2;
  end
`else
  always_comb begin
    work_d = dabble_step(work_q);
  end
`endif

  // NOTE: sequential state uses non-blocking '<='; the work register is small and
  // control-relevant, so it is reset along with everything else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      bin_q       <= '0;
      err_q       <= 1'b0;
      work_q      <= '0;
      cnt_q       <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            in_ready_q <= 1'b0;
            if (digit_err) begin
              err_q       <= 1'b1;
              bin_q       <= '0;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              work_q  <= {bcd_in, {BIN_W{1'b0}}};
              cnt_q   <= '0;
              err_q   <= 1'b0;
              state_q <= S_CONV;
            end
          end
        end
        S_CONV: begin
          work_q <= work_d;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            bin_q       <= work_d[BIN_W-1:0];
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign bin_out   = bin_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Scoreboard bench for bcd_to_binary_seq: directed vectors on a 3-digit and a 4-digit instance.
module tb_bcd_to_binary_seq;

`ifdef BCD2BIN_FAST_EN
  localparam int LAT3 = 5;
  localparam int LAT4 = 7;
`else
  localparam int LAT3 = 10;
  localparam int LAT4 = 14;
`endif

  typedef struct packed {
    logic [13:0] bin;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst_n;

  logic        in_valid, in_ready, out_valid, out_ready, err;
  logic [11:0] bcd_in;
  logic [9:0]  bin_out;

  logic        in_valid4, in_ready4, out_valid4, out_ready4, err4;
  logic [15:0] bcd_in4;
  logic [13:0] bin_out4;

  int checks   = 0;
  int failures = 0;

  exp_t sb[$];
  exp_t sb4[$];

  bcd_to_binary_seq #(.DIGITS(3), .BIN_W(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .bcd_in(bcd_in),
    .out_valid(out_valid), .out_ready(out_ready), .bin_out(bin_out), .err(err)
  );

  bcd_to_binary_seq #(.DIGITS(4), .BIN_W(14)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid4), .in_ready(in_ready4), .bcd_in(bcd_in4),
    .out_valid(out_valid4), .out_ready(out_ready4), .bin_out(bin_out4), .err(err4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Monitors: pop the expected result on every output handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_bin", 32'(bin_out), 32'(e.bin));
        check("sb_err", 32'(err), 32'(e.err));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid4 && out_ready4) begin
      if (sb4.size() == 0) begin
        check("unexpected_output4", 1, 0);
      end else begin
        exp_t e;
        e = sb4.pop_front();
        check("sb4_bin", 32'(bin_out4), 32'(e.bin));
        check("sb4_err", 32'(err4), 32'(e.err));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // All driving and sampling happens 1 time unit after a rising edge.
  task automatic send(input logic [11:0] bcd, input logic [9:0] exp_bin, input logic exp_err,
                      input int exp_lat, input int hold, input bit toggle);
    int n;
    bit busy_low;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("in_ready_idle", 32'(in_ready), 1);
    bcd_in    = bcd;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    sb.push_back('{bin: 14'(exp_bin), err: exp_err});
    @(posedge clk); #1;
    in_valid = toggle;
    n        = 0;
    busy_low = 1'b1;
    while (!out_valid && n < 100) begin
      if (in_ready) busy_low = 1'b0;
      if (toggle) bcd_in = 12'($urandom);
      @(posedge clk); #1; n++;
    end
    in_valid = 1'b0;
    check("latency", 32'(n), 32'(exp_lat));
    check("in_ready_done", 32'(in_ready), 0);
    if (exp_lat > 0) check("in_ready_busy", 32'(busy_low), 1);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("stall_valid", 32'(out_valid), 1);
      check("stall_bin", 32'(bin_out), 32'(exp_bin));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("handoff_valid_low", 32'(out_valid), 0);
    check("handoff_ready_high", 32'(in_ready), 1);
    check("hold_bin", 32'(bin_out), 32'(exp_bin));
    check("hold_err", 32'(err), 32'(exp_err));
  endtask

  initial begin
    int n;
    bit quiet;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    bcd_in     = '0;
    in_valid4  = 1'b0;
    out_ready4 = 1'b1;
    bcd_in4    = '0;
    #12;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_bin", 32'(bin_out), 0);
    check("rst_err", 32'(err), 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", 32'(in_ready), 1);

    send(12'h999, 10'd999, 1'b0, LAT3, 0, 1'b0);
    send(12'h000, 10'd0,   1'b0, LAT3, 0, 1'b0);
    send(12'h405, 10'd405, 1'b0, LAT3, 0, 1'b0);
    send(12'h1A3, 10'd0,   1'b1, 0,    0, 1'b0);
    send(12'h010, 10'd10,  1'b0, LAT3, 0, 1'b0);
    send(12'hF00, 10'd0,   1'b1, 0,    0, 1'b0);
    send(12'h080, 10'd80,  1'b0, LAT3, 0, 1'b0);
    send(12'h250, 10'd250, 1'b0, LAT3, 6, 1'b1);

    // Abort a conversion of 777 partway through with an async reset.
    bcd_in   = 12'h777;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 0);
    check("abort_bin", 32'(bin_out), 0);
    check("abort_err", 32'(err), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) quiet = 1'b0;
      @(posedge clk); #1;
    end
    check("abort_no_output", 32'(quiet), 1);
    check("abort_in_ready", 32'(in_ready), 1);

    send(12'h123, 10'd123, 1'b0, LAT3, 0, 1'b0);
    send(12'h512, 10'd512, 1'b0, LAT3, 2, 1'b0);

    // Wider instance.
    bcd_in4   = 16'h9999;
    in_valid4 = 1'b1;
    sb4.push_back('{bin: 14'd9999, err: 1'b0});
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    n = 0;
    while (!out_valid4 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("latency4", 32'(n), 32'(LAT4));
    @(posedge clk); #1;
    check("handoff4_ready", 32'(in_ready4), 1);
    check("hold4_bin", 32'(bin_out4), 32'd9999);

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 32'(sb.size()), 0);
    check("sb4_drained", 32'(sb4.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_to_binary_seq.md
Name: bcd_to_binary_seq

Overview:
Multi-cycle packed-BCD to unsigned binary converter using reverse double-dabble: shift right, then subtract 3 from any digit >= 8. It is the inverse of the team's binary-to-BCD converter. It sits between BCD sources (keypad/display scan logic, BCD counters) and binary datapaths. Input and output each use a valid/ready handshake. One conversion is in flight at a time.

Parameters:
- DIGITS, 3, number of BCD digits on bcd_in (>= 1).
- BIN_W, 10, binary result width. Must be >= ceil(log2(10^DIGITS)); elaboration error otherwise.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  bcd_in valid
- in_ready  out  1  converter can accept; high only in IDLE
- bcd_in  in  4*DIGITS  packed BCD, digit i at [4i+3:4i], digit 0 = ones
- out_valid  out  1  bin_out/err valid; high only in DONE
- out_ready  in  1  consumer accepts result
- bin_out  out  BIN_W  binary result
- err  out  1  an input digit was > 9

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_ready=1 after release; out_valid=0; bin_out=0; err=0; shift reg and iteration counter=0. Reset mid-conversion aborts it with no output.
- Accept: at a rising edge with in_valid & in_ready, bcd_in is sampled once. Later changes on bcd_in are ignored.
- Digit check at accept: if any digit > 9, then err<=1, bin_out<=0, state->DONE. out_valid appears after 1 edge and no conversion runs.
- Valid input at accept: load work reg {bcd[4*DIGITS-1:0], bin[BIN_W-1:0]} = {bcd_in, 0}; counter=0; err<=0; state->CONV.
- CONV step, one per edge: shift the whole work reg right by 1 (bcd LSB enters bin MSB), then for every digit >= 8 subtract 3 from it. After the BIN_W-th step, bin_out<=bin field and state->DONE.
- Latency: out_valid is first high after BIN_W edges following the accept edge (10 for the defaults). Throughput is one result per BIN_W+2 cycles at best.
- DONE: out_valid=1; bin_out/err held stable until out_ready=1 at an edge, then state->IDLE. Unlimited back-pressure.
- in_ready=0 in CONV and DONE; in_valid is ignored there. No back-to-back accept from DONE.
- After handoff, bin_out/err keep their last values until the next result loads. out_valid is the only qualifier.
- Arithmetic: the correction is a 4-bit unsigned subtract, never underflows (digit >= 8). Surplus BIN_W bits read 0.
- States: IDLE->CONV (valid accept), IDLE->DONE (err accept), CONV->CONV (counter < BIN_W-1), CONV->DONE (last step), DONE->IDLE (out_ready).

Optional Feature:
- Macro BCD2BIN_FAST_EN.
- Defined: each CONV edge performs two shift+correct steps chained combinationally. Step count is ceil(BIN_W/2). If BIN_W is odd, the final edge performs one step. Latency for valid input is ceil(BIN_W/2) edges (5 for the defaults). Error path, handshake and results are unchanged.
- Undefined: one step per edge, latency BIN_W.

Test Plan:
- Reset, then bcd_in=12'h999, in_valid 1 cycle, out_ready=1 -> out_valid after 10 edges (5 with FAST_EN), bin_out=999 (0x3E7), err=0, then back to IDLE with in_ready=1.
- bcd_in=12'h000 and 12'h405 sequentially -> bin_out=0 then 405 (0x195). in_ready=0 throughout each conversion.
- bcd_in=12'h1A3 -> out_valid after 1 edge, err=1, bin_out=0. Next input 12'h010 -> err=0, bin_out=10.
- out_ready held 0 for 6 cycles in DONE with bcd_in=12'h250 -> out_valid and bin_out=250 stable all 6 cycles; bcd_in toggled during CONV does not affect the result.
- rst_n pulsed low 2 cycles mid-CONV (step 4 of 12'h777) -> outputs are 0 immediately (async). Afterwards 12'h123 converts to 123 with full latency.
- DIGITS=4, BIN_W=14: bcd_in=16'h9999 -> 9999 (0x270F) after 14 edges (7 with FAST_EN).
